// File: rtl/bus_incr_pkg.sv
// Shared definitions for the enable-gated myBus data-lane counter.
package bus_incr_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   typedef logic [DATA_WIDTH_DEF-1:0] data_t;
   localparam data_t DATA_MAX = '1;
endpackage

// File: rtl/bus_incr_core.sv
// Width-parameterised counter register with incrementer and carry-derived wrap pulse.
module bus_incr_core
   import bus_incr_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter bit WRAP_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  wrap
);

   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] next_data;

   // Adding enable (rather than branching on it) lets an X on enable poison
   // the whole sum in simulation; masking then folds the clear into one path.
   assign sum       = {1'b0, data} + {{DATA_WIDTH{1'b0}}, enable};
   assign next_data = sum[DATA_WIDTH-1:0] & {DATA_WIDTH{enable}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
      end else begin
         data <= next_data;
      end
   end

   generate
      if (WRAP_EN) begin : g_wrap
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wrap <= 1'b0;
            end else begin
               wrap <= sum[DATA_WIDTH] & enable;
            end
         end
      end else begin : g_no_wrap
         assign wrap = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/bus_incr_counter.sv
// Slave end of myBus: clk/enable in and data out follow the DUT modport; rst_n and wrap are side ports.
module bus_incr_counter
   import bus_incr_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter bit WRAP_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  wrap
);

   bus_incr_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .WRAP_EN    (WRAP_EN)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .data   (data),
      .wrap   (wrap)
   );

endmodule

// File: tb/tb_bus_incr_counter.sv
// Bench for bus_incr_counter: directed scenarios plus random enable/reset against a behavioural model.
module tb_bus_incr_counter;

   localparam int W = 8;
   localparam int MODULUS = 256;

   logic         clk;
   logic         rst_n;
   logic         enable;
   logic [W-1:0] data;
   logic         wrap;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   int exp_data = 0;
   bit exp_wrap = 1'b0;

   logic [W-1:0] exp_q[$];

   bus_incr_counter #(.DATA_WIDTH(W), .WRAP_EN(1'b1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .data   (data),
      .wrap   (wrap)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   // ---------------- behavioural model ----------------
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         exp_wrap = (enable === 1'b1) && (exp_data == MODULUS - 1);
         exp_data = (enable === 1'b1) ? (exp_data + 1) % MODULUS : 0;
      end
   end

   always @(negedge rst_n) begin
      exp_data = 0;
      exp_wrap = 1'b0;
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         check("model_data", {24'd0, data}, exp_data[31:0]);
         check("model_wrap", {31'd0, wrap}, {31'd0, exp_wrap});
      end
   end

   // ---------------- driver tasks ----------------
   // Inputs are set mid-cycle, then one edge is taken; returns 5 ns after the edge.
   task automatic step(input logic en);
      enable = en;
      @(posedge clk);
      #5;
   endtask

   task automatic run(input logic en, input int n);
      for (int i = 0; i < n; i++) step(en);
   endtask

   task automatic check_queue(input string name);
      logic [W-1:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(name, {24'd0, data}, {24'd0, e});
         check({name, "_wrap"}, {31'd0, wrap}, 32'd0);
         if (exp_q.size() > 0) step(enable);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] en_pat;
      logic [W-1:0] exp_seq[8];
      rst_n  = 1'b1;
      enable = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #5 rst_n = 1'b1;
      cmp_on = 1'b1;
      check("reset_data", {24'd0, data}, 32'd0);
      check("reset_wrap", {31'd0, wrap}, 32'd0);

      // asynchronous reset assertion with data = 5
      run(1'b1, 5);
      check("pre_reset_data", {24'd0, data}, 32'd5);
      rst_n = 1'b0;
      #1;
      check("async_reset_data", {24'd0, data}, 32'd0);
      check("async_reset_wrap", {31'd0, wrap}, 32'd0);
      run(1'b1, 3);
      check("held_reset_data", {24'd0, data}, 32'd0);
      rst_n = 1'b1;

      // basic count: 1,1,0,1,1,1,1,1 -> 1,2,0,1,2,3,4,5
      en_pat = 8'b1111_1011;
      exp_seq = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      for (int i = 0; i < 8; i++) begin
         step(en_pat[i]);
         check("basic_data", {24'd0, data}, {24'd0, exp_seq[i]});
         check("basic_wrap", {31'd0, wrap}, 32'd0);
      end

      // wrap from zero
      step(1'b0);
      run(1'b1, 255);
      check("at_max_data", {24'd0, data}, 32'd255);
      check("at_max_wrap", {31'd0, wrap}, 32'd0);
      step(1'b1);
      check("wrap_data", {24'd0, data}, 32'd0);
      check("wrap_pulse", {31'd0, wrap}, 32'd1);
      step(1'b1);
      check("post_wrap_data", {24'd0, data}, 32'd1);
      check("post_wrap_pulse", {31'd0, wrap}, 32'd0);

      // clear at max takes priority over wrap
      run(1'b1, 254);
      check("max_again_data", {24'd0, data}, 32'd255);
      step(1'b0);
      check("clear_at_max_data", {24'd0, data}, 32'd0);
      check("clear_at_max_wrap", {31'd0, wrap}, 32'd0);

      // toggle enable every edge
      for (int i = 0; i < 10; i++) begin
         step(~i[0]);
         check("toggle_data", {24'd0, data}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check("toggle_wrap", {31'd0, wrap}, 32'd0);
      end

      // reset mid-operation at data = 200
      run(1'b1, 200);
      check("pre_mid_reset", {24'd0, data}, 32'd200);
      rst_n = 1'b0;
      #1;
      check("mid_reset_data", {24'd0, data}, 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #5;
      exp_q.push_back(8'd1);
      exp_q.push_back(8'd2);
      exp_q.push_back(8'd3);
      check_queue("resume");

      // random enable, long enabled bursts so wraps occur, occasional reset pulses
      for (int i = 0; i < 1200; i++) begin
         if ((i / 300) % 2 == 0) step($urandom_range(0, 3) != 0);
         else step($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end

      cmp_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
